vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Produces the 10-bit pixel coordinates consumed by all sprite and text renderers (score label, digits, players, bullets), plus the physical sync strobes and blanking flags used by the final RGB output stage. Sits directly upstream of every coordinate-driven renderer. It is the single source of `hsync`/`vsync` coordinate buses in the design.

## Interface
Parameters:
- `CLK_DIV`, 2, system clocks per pixel (50 MHz -> 25 MHz pixel rate); must be >= 1
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `pix_tick`  out  1  one-`clk` pixel enable, once every `CLK_DIV` clocks
- `h_count`  out  10  current pixel column, 0..H_TOTAL-1; drives renderer `hsync` input
- `v_count`  out  10  current line, 0..V_TOTAL-1; drives renderer `vsync` input
- `hs_n`  out  1  horizontal sync, active-low
- `vs_n`  out  1  vertical sync, active-low
- `video_on`  out  1  high when `h_count < H_ACTIVE` and `v_count < V_ACTIVE`
- `frame_tick`  out  1  one-`clk` pulse at start of each frame

## Operation
- Derived: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800), `V_TOTAL = ...` (525). All counters are 10-bit unsigned; both totals fit.
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_tick = (div_cnt == CLK_DIV-1)`. With `CLK_DIV=1`, `pix_tick` is constantly 1 out of reset.
- Raster counters advance only on clock edges where `pix_tick` is high.
  - `h_count` wraps from H_TOTAL-1 to 0.
  - `v_count` increments only when `h_count` wraps, and wraps from V_TOTAL-1 to 0.
- Sync and blanking decodes:
  - `hs_n = 0` iff `H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC` (656..751).
  - `vs_n = 0` iff `V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC` (490..491).
- `frame_tick` pulses for exactly one `clk` when the counters transition to (0,0).
- Reset state parks the raster on the last pixel of the frame:
  - `h_count = H_TOTAL-1`, `v_count = V_TOTAL-1`, `div_cnt = 0`.
  - `hs_n = 1`, `vs_n = 1`, `video_on = 0`, `frame_tick = 0`.
  - `pix_tick = 0` (1 if `CLK_DIV=1`).
  - The first counter advance therefore lands on (0,0) and fires `frame_tick`.
- Reset asserted mid-frame forces all reset values immediately, with no wait for a clock. After release, timing restarts exactly as from power-up.

## Timing
- `hs_n`, `vs_n`, `video_on` and `frame_tick` are registered. They are computed from the next-state counter values on the same edge that updates `h_count`/`v_count`, so all outputs are mutually consistent in every cycle (zero skew).
- Each coordinate is held for `CLK_DIV` clocks. Line period = H_TOTAL*CLK_DIV clocks (1600); frame period = 840000 clocks.
- With `CLK_DIV=2`: first `pix_tick` occurs 1 clock after reset release; `h_count` reaches 0 at the second edge after release.
- Downstream renderers are combinational on `h_count`/`v_count`. The output stage must gate RGB with `video_on` from the same cycle.

## Structure
- Shared package `vga_pkg` holds:
  - default timing constants (H_/V_ ACTIVE, FP, SYNC, BP);
  - derived `H_TOTAL`/`V_TOTAL`;
  - coordinate width `COORD_W = 10`.
- One sub-module is natural: `pix_tick_gen` (the `CLK_DIV` divider producing `pix_tick`, parameterised by `CLK_DIV`).
- Raster counters and decodes live in the top module.

## Test plan
- Reset hold then release, `CLK_DIV=2` -> outputs at reset values (799/524/1/1/0/0); `pix_tick` alternates 0,1 from first clock; (0,0) with `frame_tick=1` on the second edge.
- Run one line -> `hs_n` low for exactly 192 clocks starting when `h_count=656`; `video_on` high for 1280 clocks per visible line.
- Run a full frame -> `vs_n` low only on lines 490-491; `frame_tick` exactly once per 840000 clocks; `video_on` never high for `v_count >= 480`.
- Check wrap points -> (799,479) to (0,480) and (799,524) to (0,0); `h_count`/`v_count` never exceed 799/524.
- Assert `rst` asynchronously at `h_count=300`, `v_count=200` -> outputs return to reset values before the next `clk` edge; after release the frame restarts at (0,0) with `frame_tick`.
- Sweep `CLK_DIV=1` -> `pix_tick` constantly 1 after reset; line period 800 clocks; sync positions unchanged in pixel units.

Source files
------------

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing constants and a small window-decode helper
// shared by the timing generator and anything that needs raster geometry.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // True when lo <= val < lo+len; coordinates are zero-extended before comparing.
  function automatic logic in_window(input logic [COORD_W-1:0] val, input int lo, input int len);
    int v;
    v = {{(32-COORD_W){1'b0}}, val};
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// Pixel-rate divider: pix_tick is high for one clk every CLK_DIV clocks,
// on the last count of the divider; CLK_DIV=1 yields a constant tick.
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign pix_tick = (div_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v pixel counters plus registered sync, blanking and frame
// strobes, all decoded from next-state counters so every output is skew-free.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_tick,
  output logic [COORD_W-1:0] h_count,
  output logic [COORD_W-1:0] v_count,
  output logic               hs_n,
  output logic               vs_n,
  output logic               video_on,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  logic [COORD_W-1:0] h_nxt;
  logic [COORD_W-1:0] v_nxt;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  always_comb begin
    h_nxt = h_count;
    v_nxt = v_count;
    if (pix_tick) begin
      if (h_count == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_count == V_LAST) ? '0 : v_count + COORD_W'(1);
      end else begin
        h_nxt = h_count + COORD_W'(1);
      end
    end
  end

  // Reset parks on the last pixel so the first advance lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count    <= H_LAST;
      v_count    <= V_LAST;
      hs_n       <= 1'b1;
      vs_n       <= 1'b1;
      video_on   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      h_count    <= h_nxt;
      v_count    <= v_nxt;
      hs_n       <= ~in_window(h_nxt, H_ACTIVE + H_FP, H_SYNC);
      vs_n       <= ~in_window(v_nxt, V_ACTIVE + V_FP, V_SYNC);
      video_on   <= in_window(h_nxt, 0, H_ACTIVE) && in_window(v_nxt, 0, V_ACTIVE);
      frame_tick <= pix_tick && (h_nxt == '0) && (v_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three generator instances (default, CLK_DIV=1, shrunk raster with CLK_DIV=3)
// checked every clock against an edge-count model through an expected-value queue.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pix_tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs_n;
    logic       vs_n;
    logic       video_on;
    logic       frame_tick;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst        [3];
  logic       pix_tick   [3];
  logic [9:0] h_count    [3];
  logic [9:0] v_count    [3];
  logic       hs_n       [3];
  logic       vs_n       [3];
  logic       video_on   [3];
  logic       frame_tick [3];

  always #5 clk = ~clk;

  vga_timing_gen u0 (
    .clk(clk), .rst(rst[0]), .pix_tick(pix_tick[0]), .h_count(h_count[0]), .v_count(v_count[0]),
    .hs_n(hs_n[0]), .vs_n(vs_n[0]), .video_on(video_on[0]), .frame_tick(frame_tick[0])
  );

  vga_timing_gen #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst[1]), .pix_tick(pix_tick[1]), .h_count(h_count[1]), .v_count(v_count[1]),
    .hs_n(hs_n[1]), .vs_n(vs_n[1]), .video_on(video_on[1]), .frame_tick(frame_tick[1])
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u2 (
    .clk(clk), .rst(rst[2]), .pix_tick(pix_tick[2]), .h_count(h_count[2]), .v_count(v_count[2]),
    .hs_n(hs_n[2]), .vs_n(vs_n[2]), .video_on(video_on[2]), .frame_tick(frame_tick[2])
  );

  int     checks = 0;
  int     errors = 0;
  longint e [3];
  obs_t   exp_q [$];
  longint cyc = 0;

  int     hs_low_v0 = 0;
  int     vid_v0    = 0;
  int     hs_first_h = -1;
  logic   prev_hs0  = 1'b1;
  logic [9:0] prev_h1 = 10'd799;
  longint last_line1 = -1;
  int     lines1    = 0;
  longint last_ft2  = -1;
  int     ft2_cnt   = 0;

  // Position after ed edges since reset release: one pixel per CLK_DIV edges,
  // starting one pixel before (0,0).
  function automatic obs_t model(input int div, input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb, input longint ed);
    obs_t   o;
    longint ht, vt, fr, lin, hh, vv;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    fr  = ht * vt;
    lin = (fr - 1 + ed / div) % fr;
    hh  = lin % ht;
    vv  = lin / ht;
    o.pix_tick   = ((ed % div) == div - 1);
    o.h          = 10'(hh);
    o.v          = 10'(vv);
    o.hs_n       = !(hh >= ha + hf && hh < ha + hf + hs);
    o.vs_n       = !(vv >= va + vf && vv < va + vf + vs);
    o.video_on   = (hh < ha) && (vv < va);
    o.frame_tick = (ed > 0) && ((ed % div) == 0) && (lin == 0);
    return o;
  endfunction

  function automatic obs_t exp_of(input int i);
    case (i)
      0:       return model(2, 640, 16, 96, 48, 480, 10, 2, 33, e[0]);
      1:       return model(1, 640, 16, 96, 48, 480, 10, 2, 33, e[1]);
      default: return model(3, 16, 2, 4, 3, 12, 2, 2, 3, e[2]);
    endcase
  endfunction

  function automatic obs_t obs_of(input int i);
    obs_t o;
    o.pix_tick   = pix_tick[i];
    o.h          = h_count[i];
    o.v          = v_count[i];
    o.hs_n       = hs_n[i];
    o.vs_n       = vs_n[i];
    o.video_on   = video_on[i];
    o.frame_tick = frame_tick[i];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cmp(input int i, input obs_t x);
    obs_t o;
    o = obs_of(i);
    chk($sformatf("u%0d_pix_tick@%0d", i, cyc), 32'(o.pix_tick), 32'(x.pix_tick));
    chk($sformatf("u%0d_h_count@%0d", i, cyc), 32'(o.h), 32'(x.h));
    chk($sformatf("u%0d_v_count@%0d", i, cyc), 32'(o.v), 32'(x.v));
    chk($sformatf("u%0d_hs_n@%0d", i, cyc), 32'(o.hs_n), 32'(x.hs_n));
    chk($sformatf("u%0d_vs_n@%0d", i, cyc), 32'(o.vs_n), 32'(x.vs_n));
    chk($sformatf("u%0d_video_on@%0d", i, cyc), 32'(o.video_on), 32'(x.video_on));
    chk($sformatf("u%0d_frame_tick@%0d", i, cyc), 32'(o.frame_tick), 32'(x.frame_tick));
  endtask

  task automatic step();
    for (int i = 0; i < 3; i++) begin
      if (!rst[i]) e[i]++;
      exp_q.push_back(exp_of(i));
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) cmp(i, exp_q.pop_front());
    if (!rst[0] && v_count[0] == 10'd0) begin
      if (!hs_n[0]) hs_low_v0++;
      if (video_on[0]) vid_v0++;
      if (!hs_n[0] && prev_hs0 && hs_first_h < 0) hs_first_h = int'(h_count[0]);
    end
    prev_hs0 = hs_n[0];
    if (!rst[1] && h_count[1] == 10'd0 && prev_h1 != 10'd0) begin
      if (last_line1 >= 0) chk("u1_line_period", 32'(cyc - last_line1), 32'd800);
      last_line1 = cyc;
      lines1++;
    end
    prev_h1 = h_count[1];
    if (frame_tick[2]) begin
      if (last_ft2 >= 0) chk("u2_frame_period", 32'(cyc - last_ft2), 32'd1425);
      last_ft2 = cyc;
      ft2_cnt++;
    end
  endtask

  initial begin
    obs_t x;
    int   found;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      e[i]   = 0;
    end
    #2;
    chk("rst_async_h0", 32'(h_count[0]), 32'd799);
    repeat (3) step();
    chk("rst_h0", 32'(h_count[0]), 32'd799);
    chk("rst_v0", 32'(v_count[0]), 32'd524);
    chk("rst_hs0", 32'(hs_n[0]), 32'd1);
    chk("rst_vs0", 32'(vs_n[0]), 32'd1);
    chk("rst_vid0", 32'(video_on[0]), 32'd0);
    chk("rst_ft0", 32'(frame_tick[0]), 32'd0);
    chk("rst_tick0", 32'(pix_tick[0]), 32'd0);
    chk("rst_tick1", 32'(pix_tick[1]), 32'd1);

    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    step();
    chk("edge1_tick0", 32'(pix_tick[0]), 32'd1);
    chk("edge1_h0", 32'(h_count[0]), 32'd799);
    chk("edge1_h1", 32'(h_count[1]), 32'd0);
    chk("edge1_ft1", 32'(frame_tick[1]), 32'd1);
    step();
    chk("edge2_h0", 32'(h_count[0]), 32'd0);
    chk("edge2_v0", 32'(v_count[0]), 32'd0);
    chk("edge2_ft0", 32'(frame_tick[0]), 32'd1);
    chk("edge2_tick0", 32'(pix_tick[0]), 32'd0);

    repeat (1998) step();
    chk("u0_hs_low_clocks", 32'(hs_low_v0), 32'd192);
    chk("u0_hs_first_h", 32'(hs_first_h), 32'd656);
    chk("u0_video_clocks", 32'(vid_v0), 32'd1280);
    chk("u1_lines_seen", 32'(lines1), 32'd3);
    chk("u2_frames_seen", 32'(ft2_cnt), 32'd2);

    found = 0;
    for (int k = 0; k < 1500 && found == 0; k++) begin
      x = exp_of(2);
      if (x.h == 10'd10 && x.v == 10'd6) found = 1;
      else step();
    end
    chk("u2_reach_10_6", 32'(found), 32'd1);
    chk("u2_pre_async_h", 32'(h_count[2]), 32'd10);
    #2;
    rst[2]   = 1'b1;
    e[2]     = 0;
    last_ft2 = -1;
    #1;
    chk("async_h2", 32'(h_count[2]), 32'd24);
    chk("async_v2", 32'(v_count[2]), 32'd18);
    chk("async_hs2", 32'(hs_n[2]), 32'd1);
    chk("async_vs2", 32'(vs_n[2]), 32'd1);
    chk("async_vid2", 32'(video_on[2]), 32'd0);
    chk("async_ft2", 32'(frame_tick[2]), 32'd0);
    chk("async_tick2", 32'(pix_tick[2]), 32'd0);
    repeat (2) step();
    rst[2]  = 1'b0;
    ft2_cnt = 0;
    repeat (3) step();
    chk("restart_h2", 32'(h_count[2]), 32'd0);
    chk("restart_v2", 32'(v_count[2]), 32'd0);
    chk("restart_ft2", 32'(frame_tick[2]), 32'd1);
    repeat (1500) step();
    chk("u2_frames_after_restart", 32'(ft2_cnt), 32'd2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
